out_buffer: RTL

Output-side UART stage for the CPU core. It sits directly downstream of the ALU's OUT path: when an OUT instruction retires, the ALU result is pushed into a FIFO. The block then serialises entries onto `txd` as 8N1 frames. It back-pressures the pipeline with `out_ready` when the FIFO is full.

---
 rtl/out_buffer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/out_buffer.sv
// out_buffer: FIFO-backed 8N1 UART transmitter fed by the CPU OUT path.
// Entries are pushed on is_out and drained LSB-first onto txd, back-to-back.
// Build option: define OUT_FULL_WORD_EN to store 32-bit entries and send each
// one as four frames (bytes [7:0], [15:8], [23:16], [31:24]).
module out_buffer #(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int BUFFER_SIZE      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_out,
    input  logic [31:0] out_data,
    output logic        out_ready,
    output logic        out_empty,
    output logic        out_ovf,
    output logic        txd
);

    localparam int BIT    = 2 * CLK_PER_HALF_BIT;
    localparam int BAUD_W = (BIT > 2) ? $clog2(BIT) : 1;
    localparam int DEPTH  = 1 << BUFFER_SIZE;
`ifdef OUT_FULL_WORD_EN
    localparam int DW    = 32;
    localparam int BYTES = 4;
`else
    localparam int DW    = 8;
    localparam int BYTES = 1;
`endif

    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(BIT - 1);
    localparam logic [BUFFER_SIZE:0] DEPTH_C   = (BUFFER_SIZE + 1)'(DEPTH);
    localparam logic [1:0]           BYTE_LAST = 2'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [DW-1:0]          mem_q [DEPTH];
    logic [BUFFER_SIZE-1:0] top_q, top_d;
    logic [BUFFER_SIZE-1:0] bot_q, bot_d;
    logic [BUFFER_SIZE:0]   count_q, count_d;
    logic                   ovf_q, ovf_d;

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [DW-1:0]          shift_q, shift_d;
    logic                   txd_q, txd_d;

    logic                   push;
    logic                   pop;
    logic                   baud_tc;
    logic [DW-1:0]          wr_data;

`ifdef OUT_FULL_WORD_EN
    assign wr_data = out_data;
`else
    logic unused_hi;
    assign wr_data   = out_data[7:0];
    assign unused_hi = ^out_data[31:8];
`endif

    // Fullness is judged on the pre-edge count, so a push while full is
    // dropped even when the transmitter pops on the same edge.
    assign push      = is_out && (count_q != DEPTH_C);
    assign baud_tc   = (baud_q == BAUD_LAST);

    assign out_ready = (count_q != DEPTH_C);
    assign out_empty = (count_q == '0) && (state_q == S_IDLE);
    assign out_ovf   = ovf_q;
    assign txd       = txd_q;

    // Transmitter next-state: baud timing, bit/byte sequencing, pop on load.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[bot_q];
                    byte_idx_d = '0;
                    baud_d     = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_d = '0;
                    if (byte_idx_q != BYTE_LAST) begin
                        // Shift register already holds the next byte in [7:0].
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_START;
                    end else if (count_q != '0) begin
                        pop        = 1'b1;
                        shift_d    = mem_q[bot_q];
                        byte_idx_d = '0;
                        state_d    = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        // Line level is registered from the next state so txd never glitches.
        if (state_d == S_START) begin
            txd_d = 1'b0;
        end else if (state_d == S_DATA) begin
            txd_d = shift_d[0];
        end else begin
            txd_d = 1'b1;
        end
    end

    // FIFO next-state: pointers wrap naturally at depth; count tracks push/pop.
    always_comb begin
        top_d   = top_q;
        bot_d   = bot_q;
        count_d = count_q;
        ovf_d   = ovf_q | (is_out & ~push);
        if (push) begin
            top_d = top_q + 1'b1;
        end
        if (pop) begin
            bot_d = bot_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[top_q] <= wr_data;
        end
    end

    // Control and transmitter registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q      <= '0;
            bot_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            top_q      <= top_d;
            bot_q      <= bot_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
        end
    end

endmodule
